lcd_cmd_host: RTL
=================

Name: lcd_cmd_host

Overview:
- Host-side counterpart of the LCD controller. Upstream commands go into a small FIFO and are issued to the controller under its busy/cmd_valid handshake.
- The block also acts as the image-buffer responder on the IRB write port. It captures the 64-byte write-back frame, accumulates a checksum and reports frame completion and integrity errors.
- Sits between the test/host sequencer and the LCD controller. The captured frame can be read back through a side read port.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two).
- ADDR_W, 6, IRB address width.
- DATA_W, 8, pixel width.
- NPIX, 64, pixels expected per write-back frame.
- CKSUM_W, 16, checksum width (modulo 2^CKSUM_W sum).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- host_cmd  in  3  command code (0 WRTBK, 1 UP, 2 DN, 3 LF, 4 RT, 5 AVG, 6 MRR_X, 7 MRR_Y).
- host_valid  in  1  push request.
- host_ready  out  1  FIFO not full; push occurs when host_valid&host_ready.
- cmd  out  3  command to controller (registered).
- cmd_valid  out  1  one-cycle issue strobe (registered).
- busy  in  1  controller busy.
- done  in  1  controller frame done.
- IRB_RW  in  1  0 = write strobe from controller.
- IRB_A  in  ADDR_W  write address.
- IRB_D  in  DATA_W  write data.
- rd_addr  in  ADDR_W  capture-buffer read address.
- rd_data  out  DATA_W  captured pixel; 1-cycle registered read.
- frame_valid  out  1  one-cycle pulse when the frame report is ready.
- cksum  out  CKSUM_W  sum of all captured IRB_D values; held after frame_valid.
- wr_count  out  7  number of IRB writes seen this frame (saturates at 127).
- err  out  1  sticky integrity error.

Behaviour:
- Reset (reset==0 at a rising edge) values:
  - cmd=0, cmd_valid=0, frame_valid=0, cksum=0, wr_count=0, err=0, rd_data=0.
  - FIFO emptied; written-flag vector cleared; state=WAIT_RDY.
  - Reset mid-frame aborts everything; capture contents are don't-care.
- host_ready = ~fifo_full, combinational from the FIFO count. A push while full is ignored. Push and pop in the same cycle are legal when not full, and the count is unchanged.
- FSM:
  - WAIT_RDY: cmd_valid=0; go to RUN on the first cycle busy==0.
  - RUN: if fifo non-empty and busy==0, pop the head and register cmd=head, cmd_valid=1 on the next edge. Back-to-back issue is allowed (one per cycle). If the popped command is 0 (WRTBK), go to WB in the same edge. If the FIFO is empty or busy==1, cmd_valid=0.
  - WB: no issue (cmd_valid=0); FIFO still accepts pushes. Capture IRB writes. Go to FIN when done==1.
  - FIN: frame_valid=1 for exactly the transition edge, then 0. Remain in FIN until reset. Ignore busy/IRB.
- Capture, in any state except FIN, on each rising edge with IRB_RW==0:
  - mem[IRB_A] <= IRB_D.
  - cksum <= cksum + IRB_D (zero-extended, wraps mod 2^CKSUM_W).
  - wr_count++ (saturating at 127).
  - Set written[IRB_A]; if written[IRB_A] was already set, err<=1 (duplicate address).
- IRB writes while in WAIT_RDY or RUN: err<=1, but the data is still captured.
- On the FIN entry edge: err<=1 if wr_count!=NPIX (count includes a write on the same edge).
- done asserted before any WRTBK was issued: go to FIN, err<=1.
- rd_data <= mem[rd_addr] every cycle, independent of state.

Decomposition:
- Shared package lcd_pkg: the command code constants (WRTBK..MRR_Y) and the NPIX / ADDR_W / DATA_W constants, shared with the controller.
- One sub-module, cmd_fifo: synchronous FIFO with depth FIFO_DEPTH, width 3, push/pop/full/empty/head.
- Capture memory and checksum stay inline.

Test Plan:
- Reset, then hold busy=1 for 70 cycles, then busy=0 -> cmd_valid stays 0 until busy falls; the first queued command appears 1 cycle after the first issue edge.
- Push UP, RT, AVG, MRR_X back-to-back with busy=0 -> cmd_valid high 4 consecutive cycles with cmd=1,4,5,6; host_ready never drops at depth 4.
- Push 5 commands while busy=1 -> host_ready=0 after the 4th; the 5th is not stored; after busy=0 exactly 4 commands are issued.
- Push WRTBK then RT; controller writes addresses 0..63 with data=addr -> RT is never issued; frame_valid pulses once; cksum=2016; wr_count=64; err=0; rd_addr=10 gives rd_data=10 on the next cycle.
- Same write-back but address 5 written twice and 63 omitted -> frame_valid pulses; wr_count=64; err=1.
- Assert reset=0 mid write-back (after 20 writes), then re-run a clean frame -> cksum/wr_count restart from 0; err=0 at the second frame_valid.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD command codes, frame geometry and host FSM states
package lcd_pkg;

    localparam int LCD_ADDR_W     = 6;
    localparam int LCD_DATA_W     = 8;
    localparam int LCD_NPIX       = 64;
    localparam int LCD_CKSUM_W    = 16;
    localparam int LCD_FIFO_DEPTH = 4;
    localparam int LCD_CMD_W      = 3;

    typedef enum logic [LCD_CMD_W-1:0] {
        CMD_WRTBK = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DN    = 3'd2,
        CMD_LF    = 3'd3,
        CMD_RT    = 3'd4,
        CMD_AVG   = 3'd5,
        CMD_MRR_X = 3'd6,
        CMD_MRR_Y = 3'd7
    } lcd_cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_RDY = 2'd0,
        ST_RUN      = 2'd1,
        ST_WB       = 2'd2,
        ST_FIN      = 2'd3
    } host_state_e;

endpackage

// File: rtl/lcd_cmd_host_cmd_fifo.sv
// rtl/lcd_cmd_host_cmd_fifo.sv - small synchronous command FIFO
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped; popping an empty one does nothing.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Entry storage; stale contents behind the pointers are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/lcd_cmd_host.sv
// rtl/lcd_cmd_host.sv - host command issuer and IRB write-back frame capture
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = LCD_FIFO_DEPTH,
    parameter int ADDR_W     = LCD_ADDR_W,
    parameter int DATA_W     = LCD_DATA_W,
    parameter int NPIX       = LCD_NPIX,
    parameter int CKSUM_W    = LCD_CKSUM_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         host_cmd,
    input  logic               host_valid,
    output logic               host_ready,
    output logic [2:0]         cmd,
    output logic               cmd_valid,
    input  logic               busy,
    input  logic               done,
    input  logic               IRB_RW,
    input  logic [ADDR_W-1:0]  IRB_A,
    input  logic [DATA_W-1:0]  IRB_D,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic               frame_valid,
    output logic [CKSUM_W-1:0] cksum,
    output logic [6:0]         wr_count,
    output logic               err
);

    localparam int MEM_DEPTH = 1 << ADDR_W;

    host_state_e        state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               frame_valid_q, frame_valid_d;
    logic [CKSUM_W-1:0] cksum_q, cksum_d;
    logic [6:0]         wr_count_q, wr_count_d;
    logic               err_q, err_d;
    logic [MEM_DEPTH-1:0] written_q, written_d;
    logic [DATA_W-1:0]  rd_data_q;
    logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

    logic               fifo_pop, fifo_full, fifo_empty;
    logic [2:0]         fifo_head;
    logic               wr_en, pre_wb, enter_fin;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_cmd_fifo (
        .clk         (clk),
        .resetn_i    (reset),
        .push_i      (host_valid),
        .push_data_i (host_cmd),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign host_ready  = ~fifo_full;
    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_valid = frame_valid_q;
    assign cksum       = cksum_q;
    assign wr_count    = wr_count_q;
    assign err         = err_q;
    assign rd_data     = rd_data_q;

    // Once the frame is reported, the IRB port is no longer listened to.
    assign wr_en  = !IRB_RW && (state_q != ST_FIN);
    assign pre_wb = (state_q == ST_WAIT_RDY) || (state_q == ST_RUN);

    // Issue FSM: next state, FIFO pop and the registered command strobe.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        case (state_q)
            ST_WAIT_RDY: begin
                if (done)       state_d = ST_FIN;
                else if (!busy) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (done) begin
                    state_d = ST_FIN;
                end else if (!fifo_empty && !busy) begin
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_head;
                    cmd_valid_d = 1'b1;
                    if (fifo_head == CMD_WRTBK) state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (done) state_d = ST_FIN;
            end
            default: state_d = ST_FIN;
        endcase
    end

    assign enter_fin     = (state_d == ST_FIN) && (state_q != ST_FIN);
    assign frame_valid_d = enter_fin;

    // Frame accounting: checksum, saturating write count, duplicate tracking, error.
    always_comb begin
        cksum_d    = cksum_q;
        wr_count_d = wr_count_q;
        written_d  = written_q;
        err_d      = err_q;
        if (wr_en) begin
            cksum_d    = cksum_q + CKSUM_W'(IRB_D);
            wr_count_d = (wr_count_q == 7'd127) ? wr_count_q : wr_count_q + 7'd1;
            written_d[IRB_A] = 1'b1;
            if (written_q[IRB_A] || pre_wb) err_d = 1'b1;
        end
        if (done && pre_wb) err_d = 1'b1;
        if (enter_fin && (wr_count_d != 7'(NPIX))) err_d = 1'b1;
    end

    // Control and report registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_WAIT_RDY;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            cksum_q       <= '0;
            wr_count_q    <= '0;
            err_q         <= 1'b0;
            written_q     <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_valid_q <= frame_valid_d;
            cksum_q       <= cksum_d;
            wr_count_q    <= wr_count_d;
            err_q         <= err_d;
            written_q     <= written_d;
            rd_data_q     <= mem_q[rd_addr];
        end
    end

    // Capture buffer; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[IRB_A] <= IRB_D;
    end

endmodule
